// File: rtl/demux_sequencer.sv
// Serialises one byte onto a 1-bit data line plus a 3-bit select for a downstream 8-way demux.
// Latency: first beat one cycle after accept, 8*HOLD beats, done pulse, ready again the cycle after.
// Backpressure: in_ready is high only in IDLE; input is ignored while a byte is being distributed.
module demux_sequencer #(
  parameter int HOLD  = 1,  // cycles each sel value is held, 1..16
  parameter int ORDER = 0   // 0: sel 0->7, 1: sel 7->0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       a,
  output logic [2:0] sel,
  output logic       a_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Channel order endpoints and the terminal hold count.
  localparam logic [2:0] FIRST_SEL = (ORDER != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_SEL  = (ORDER != 0) ? 3'd0 : 3'd7;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic [7:0] held;
  logic [2:0] next_sel;

  // Next channel in the configured direction; only used when sel is not the last index,
  // so the 3-bit wrap never reaches the outputs.
  assign next_sel = (ORDER != 0) ? (sel - 3'd1) : (sel + 3'd1);

  // Single FSM: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      held     <= 8'h00;
      in_ready <= 1'b1;
      a        <= 1'b0;
      sel      <= 3'd0;
      a_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is already high here, so in_valid alone completes the handshake.
          if (in_valid) begin
            state    <= SEND;
            held     <= in_data;
            hold_cnt <= 4'd0;
            sel      <= FIRST_SEL;
            a        <= in_data[FIRST_SEL];
            a_valid  <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        SEND: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 4'd0;
            if (sel == LAST_SEL) begin
              // Last channel has had its full hold; quiesce the demux and pulse done.
              state   <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              a_valid <= 1'b0;
              a       <= 1'b0;
              sel     <= 3'd0;
            end else begin
              sel <= next_sel;
              a   <= held[next_sel];
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end

        default: begin
          state    <= IDLE;
          hold_cnt <= 4'd0;
          held     <= 8'h00;
          in_ready <= 1'b1;
          a        <= 1'b0;
          sel      <= 3'd0;
          a_valid  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer: four instances cover HOLD/ORDER combinations.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Observed vector per instance is {in_ready, busy, a_valid, a, sel[2:0], done}.
module tb_demux_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] iv;
  logic [7:0] din;

  logic [3:0] rdy_w, busy_w, av_w, a_w, done_w;
  logic [2:0] sel_w [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_sequencer #(.HOLD(1), .ORDER(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(din), .in_ready(rdy_w[0]),
    .a(a_w[0]), .sel(sel_w[0]), .a_valid(av_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  demux_sequencer #(.HOLD(3), .ORDER(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(din), .in_ready(rdy_w[1]),
    .a(a_w[1]), .sel(sel_w[1]), .a_valid(av_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  demux_sequencer #(.HOLD(2), .ORDER(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(din), .in_ready(rdy_w[2]),
    .a(a_w[2]), .sel(sel_w[2]), .a_valid(av_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  demux_sequencer #(.HOLD(16), .ORDER(0)) d3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_data(din), .in_ready(rdy_w[3]),
    .a(a_w[3]), .sel(sel_w[3]), .a_valid(av_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  function automatic logic [7:0] obs(input int d);
    return {rdy_w[d], busy_w[d], av_w[d], a_w[d], sel_w[d], done_w[d]};
  endfunction

  // Reset state on every instance, both during and just after reset.
  task automatic test_reset;
    rst = 1'b1; iv = 4'b0; din = 8'h00;
    #3;
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (obs(d) !== 8'h80) begin
        fails++; $display("FAIL reset_hold d%0d: got %h want 80", d, obs(d));
      end
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tests++;
    if (obs(0) !== 8'h80) begin
      fails++; $display("FAIL reset_release: got %h want 80", obs(0));
    end
  endtask

  // HOLD=1 ORDER=0, byte A5: sel 0..7, a=1,0,1,0,0,1,0,1, done cycle 9, ready cycle 10.
  task automatic test_lsb_first;
    logic [7:0] exp_a;
    exp_a = 8'b1010_0101;   // bit i is the expected a at sel=i
    din = 8'hA5; iv[0] = 1'b1;
    @(negedge clk); iv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs(0) !== {3'b011, exp_a[i], 3'(i), 1'b0}) begin
        fails++; $display("FAIL lsb_beat%0d: got %h want %h", i, obs(0), {3'b011, exp_a[i], 3'(i), 1'b0});
      end
      @(negedge clk);
    end
    tests++;
    if (obs(0) !== 8'h01) begin
      fails++; $display("FAIL lsb_done: got %h want 01", obs(0));
    end
    @(negedge clk);
    tests++;
    if (obs(0) !== 8'h80) begin
      fails++; $display("FAIL lsb_ready: got %h want 80", obs(0));
    end
  endtask

  // HOLD=3 ORDER=1, byte 81: sel 7 (a=1), 6..1 (a=0), 0 (a=1), 3 cycles each, done cycle 25.
  task automatic test_msb_hold3;
    logic [2:0] s;
    logic       b;
    din = 8'h81; iv[1] = 1'b1;
    @(negedge clk); iv[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      s = 3'(7 - j);
      b = (s == 3'd7 || s == 3'd0);
      for (int h = 0; h < 3; h++) begin
        tests++;
        if (obs(1) !== {3'b011, b, s, 1'b0}) begin
          fails++; $display("FAIL msb_beat sel%0d h%0d: got %h want %h", s, h, obs(1), {3'b011, b, s, 1'b0});
        end
        @(negedge clk);
      end
    end
    tests++;
    if (obs(1) !== 8'h01) begin
      fails++; $display("FAIL msb_done: got %h want 01", obs(1));
    end
    @(negedge clk);
    tests++;
    if (obs(1) !== 8'h80) begin
      fails++; $display("FAIL msb_ready: got %h want 80", obs(1));
    end
  endtask

  // Input changes during SEND of 00 are ignored; FF is taken in the next IDLE cycle.
  task automatic test_ignore_during_send;
    int w;
    din = 8'h00; iv[0] = 1'b1;
    @(negedge clk); din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs(0) !== {4'b0110, 3'(i), 1'b0}) begin
        fails++; $display("FAIL ignore_beat%0d: got %h want %h", i, obs(0), {4'b0110, 3'(i), 1'b0});
      end
      @(negedge clk);
    end
    tests++;
    if (obs(0) !== 8'h01) begin
      fails++; $display("FAIL ignore_done: got %h want 01", obs(0));
    end
    @(negedge clk);
    tests++;
    if (obs(0) !== 8'h80) begin
      fails++; $display("FAIL ignore_idle: got %h want 80", obs(0));
    end
    @(negedge clk); iv[0] = 1'b0;
    tests++;
    if (obs(0) !== 8'h70) begin
      fails++; $display("FAIL ignore_ff_first: got %h want 70", obs(0));
    end
    w = 0;
    while (obs(0) !== 8'h80 && w < 20) begin
      @(negedge clk); w++;
    end
    tests++;
    if (obs(0) !== 8'h80) begin
      fails++; $display("FAIL ignore_drain: got %h want 80", obs(0));
    end
  endtask

  // Asynchronous reset at sel=4 clears outputs before the next edge, no done, then 3C.
  task automatic test_async_reset;
    logic [7:0] b;
    din = 8'hAA; iv[0] = 1'b1;
    @(negedge clk); iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (obs(0) !== 8'h68) begin
      fails++; $display("FAIL areset_pre: got %h want 68", obs(0));
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs(0) !== 8'h80) begin
      fails++; $display("FAIL areset_mid: got %h want 80", obs(0));
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs(0) !== 8'h80) begin
        fails++; $display("FAIL areset_nodone%0d: got %h want 80", i, obs(0));
      end
    end
    b = 8'h3C;
    din = b; iv[0] = 1'b1;
    @(negedge clk); iv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs(0) !== {3'b011, b[i], 3'(i), 1'b0}) begin
        fails++; $display("FAIL areset_3c_beat%0d: got %h want %h", i, obs(0), {3'b011, b[i], 3'(i), 1'b0});
      end
      @(negedge clk);
    end
    tests++;
    if (obs(0) !== 8'h01) begin
      fails++; $display("FAIL areset_3c_done: got %h want 01", obs(0));
    end
    @(negedge clk);
  endtask

  // in_valid held high with HOLD=1: one accept every 10 cycles, never ready while busy.
  task automatic test_back_to_back;
    int acc[$];
    int viol;
    int w;
    viol = 0;
    din = 8'h5A; iv[0] = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (busy_w[0] && rdy_w[0]) viol++;
      if (rdy_w[0] && iv[0]) acc.push_back(c);
      @(negedge clk);
    end
    iv[0] = 1'b0;
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL b2b_ready_while_busy: got %0d want 0", viol);
    end
    tests++;
    if (acc.size() != 4) begin
      fails++; $display("FAIL b2b_accepts: got %0d want 4", acc.size());
    end
    for (int k = 1; k < acc.size(); k++) begin
      tests++;
      if (acc[k] - acc[k-1] != 10) begin
        fails++; $display("FAIL b2b_spacing%0d: got %0d want 10", k, acc[k] - acc[k-1]);
      end
    end
    w = 0;
    while (obs(0) !== 8'h80 && w < 20) begin
      @(negedge clk); w++;
    end
  endtask

  // Downstream demux model: yi = a when sel==i, else 0; rebuild byte from yi.
  task automatic test_scoreboard(input int d, input int hold);
    logic [7:0] b, rebuilt, y;
    int         beats, w;
    bit         got_done;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      w = 0;
      while (!rdy_w[d] && w < 300) begin
        @(negedge clk); w++;
      end
      if (!rdy_w[d]) begin
        tests++; fails++;
        $display("FAIL sb_idle_timeout d%0d: got ready=0 want 1", d);
        return;
      end
      din = b; iv[d] = 1'b1;
      @(negedge clk); iv[d] = 1'b0;
      rebuilt = 8'h00; beats = 0; got_done = 1'b0;
      for (int k = 0; k < 8 * hold + 4; k++) begin
        y = av_w[d] ? ({7'b0, a_w[d]} << sel_w[d]) : 8'h00;
        if (av_w[d]) begin
          rebuilt[sel_w[d]] = y[sel_w[d]];
          beats++;
        end
        if (done_w[d]) begin
          got_done = 1'b1;
          break;
        end
        @(negedge clk);
      end
      tests++;
      if (!got_done || rebuilt !== b) begin
        fails++; $display("FAIL sb_byte d%0d n%0d: got %h done=%0d want %h", d, n, rebuilt, got_done, b);
      end
      tests++;
      if (beats != 8 * hold) begin
        fails++; $display("FAIL sb_beats d%0d n%0d: got %0d want %0d", d, n, beats, 8 * hold);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lsb_first;
    test_msb_hold3;
    test_ignore_during_send;
    test_async_reset;
    test_back_to_back;
    test_scoreboard(0, 1);
    test_scoreboard(2, 2);
    test_scoreboard(3, 16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
